addr_decoding_prog: RTL and testbench



---
 rtl/addr_decoding_prog.sv | 52 +++++
 tb/tb_addr_decoding_prog.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/addr_decoding_prog.sv
// -----------------------------------------------------------------------------
// addr_decoding_prog
//
// Program-memory chip-select decoder for the MIPS instruction fetch path.
// It compares the fetch byte address against an inclusive window
// [PROG_BASE, PROG_LAST] and registers the result as the program-memory chip
// select. The full 32 bits take part in the compare, so there is no aliasing
// and no alignment masking.
//
// Parameters:
//   PROG_BASE  first byte address of the window (inclusive)
//   PROG_LAST  last byte address of the window (inclusive), PROG_LAST >= PROG_BASE
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous reset, active low; clears CS_P at once
//   ADDR_Prog  32-bit instruction fetch byte address
//   CS_P       program-memory chip select, active high, one clock latency
// -----------------------------------------------------------------------------
module addr_decoding_prog #(
  parameter logic [31:0] PROG_BASE = 32'h0000_4000,
  parameter logic [31:0] PROG_LAST = 32'h0000_47FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADDR_Prog,
  output logic        CS_P
);

  logic cs_d;
  logic cs_q;

  // Unsigned full-width window compare; both bounds inclusive.
  always_comb begin
    cs_d = (ADDR_Prog >= PROG_BASE) && (ADDR_Prog <= PROG_LAST);
  end

  // Registering the select keeps CS_P free of glitches from address
  // transitions between edges.
  // NOTE: non-blocking assignment in clocked logic so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q <= 1'b0;
    end else begin
      cs_q <= cs_d;
    end
  end

  assign CS_P = cs_q;

endmodule

// File: tb/tb_addr_decoding_prog.sv
// -----------------------------------------------------------------------------
// tb_addr_decoding_prog
//
// Self-checking bench for addr_decoding_prog with default parameters.
// A behavioural model predicts CS_P from the window rule; a compare process
// checks the DUT against it on every falling clock edge. Directed scenarios
// pin literal expectations for reset, boundaries, aliasing, mid-cycle address
// changes and asynchronous reset, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_addr_decoding_prog;

  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam logic [31:0] LAST = 32'h0000_47FF;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        cs_p;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  logic exp_cs = 1'b0;

  addr_decoding_prog #(
    .PROG_BASE(BASE),
    .PROG_LAST(LAST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ADDR_Prog(addr),
    .CS_P     (cs_p)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Window membership via the offset from the base, computed in 64 bits.
  function automatic logic in_window(input logic [31:0] a);
    longint off;
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    return (off >= 0) && (off <= longint'({32'h0, LAST}) - longint'({32'h0, BASE}));
  endfunction

  // Reference: low reset clears the select at once; otherwise each rising
  // edge captures the window membership of the address present at that edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) exp_cs <= 1'b0;
    else      exp_cs <= in_window(addr);
  end

  task automatic check(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s at %0t: CS_P=%b expected=%b (addr=%h rst=%b)",
               name, $time, actual, expected, addr, rst);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) check("model", cs_p, exp_cs);
  end

  // Drive an address mid-cycle, then check CS_P just after the next rising edge.
  task automatic apply(input logic [31:0] a, input logic exp, input string name);
    @(negedge clk);
    #10 addr = a;
    @(posedge clk);
    #1 check(name, cs_p, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int sel;

    rst  = 1'b1;
    addr = 32'h0000_4600;
    #5 rst = 1'b0;
    #1 check("reset_async", cs_p, 1'b0);
    chk_en = 1'b1;

    // Reset held with an in-window address: CS_P must stay low across edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("reset_hold", cs_p, 1'b0);
    end

    // Release mid-cycle; first edge after release loads the hit.
    @(negedge clk);
    #10 rst = 1'b1;
    #1 check("reset_release_pre", cs_p, 1'b0);
    @(posedge clk);
    #1 check("reset_release", cs_p, 1'b1);

    // Basic sequence.
    apply(32'h0000_4600, 1'b1, "seq_4600");
    apply(32'h0000_4800, 1'b0, "seq_4800");
    apply(32'h0000_4000, 1'b1, "seq_4000");
    apply(32'h0000_14F0, 1'b0, "seq_14f0");

    // Boundaries, alignment and aliasing.
    apply(32'h0000_3FFF, 1'b0, "bnd_3fff");
    apply(32'h0000_4000, 1'b1, "bnd_4000");
    apply(32'h0000_47FF, 1'b1, "bnd_47ff");
    apply(32'h0000_4800, 1'b0, "bnd_4800");
    apply(32'hFFFF_FFFF, 1'b0, "bnd_ffffffff");
    apply(32'h0000_0000, 1'b0, "bnd_0");
    apply(32'h0000_4001, 1'b1, "unaligned_4001");
    apply(32'h0001_4600, 1'b0, "alias_14600");
    apply(32'h8000_4000, 1'b0, "alias_80004000");

    // Back-to-back hits keep CS_P high.
    apply(32'h0000_4004, 1'b1, "b2b_0");
    apply(32'h0000_4008, 1'b1, "b2b_1");

    // Mid-cycle change from a miss to a hit takes effect only at the next edge.
    apply(32'h0000_14F0, 1'b0, "mid_pre");
    #25 addr = 32'h0000_4600;
    #1 check("mid_no_effect", cs_p, 1'b0);
    @(posedge clk);
    #1 check("mid_next_edge", cs_p, 1'b1);

    // Short glitch to a miss address between edges has no effect.
    #20 addr = 32'h0000_4800;
    #5 check("glitch_during", cs_p, 1'b1);
    #5 addr = 32'h0000_4600;
    @(posedge clk);
    #1 check("glitch_after", cs_p, 1'b1);

    // Asynchronous reset mid-operation.
    apply(32'h0000_4400, 1'b1, "async_pre");
    #20 rst = 1'b0;
    #1 check("async_clear", cs_p, 1'b0);
    #10 rst = 1'b1;
    #1 check("async_released", cs_p, 1'b0);
    @(posedge clk);
    #1 check("async_restore", cs_p, 1'b1);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: a = BASE + $urandom_range(0, 32'h7FF);
        1: a = BASE - $urandom_range(1, 4);
        2: a = LAST + $urandom_range(0, 4) - 32'd2;
        3: a = (BASE + $urandom_range(0, 32'h7FF)) | ($urandom_range(1, 32'hFFFF) << 16);
        default: a = $urandom;
      endcase
      #10 addr = a;
      if ($urandom_range(0, 19) == 0) begin
        #5 rst = 1'b0;
        #1 check("rand_async", cs_p, 1'b0);
        #5 rst = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
